// File: rtl/inst_fetch_unit_if.sv
// Fetch-unit signal bundle: PC-calculator side, like-SRAM instruction bus and decode side.
// master = fetch unit view, slave = environment (PC calc / bus / decode) view.
interface inst_fetch_unit_if;
    logic [31:0] pc_in;
    logic        pc_valid;
    logic        flush;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        fs_addr_ok;
    logic        fs_data_ok;
    logic        fs_valid;
    logic [31:0] fs_inst;
    logic [31:0] fs_pc;
    logic        ds_allow_in;

    modport master (
        input  pc_in, pc_valid, flush, inst_addr_ok, inst_data_ok, inst_rdata, ds_allow_in,
        output inst_req, inst_addr, fs_addr_ok, fs_data_ok, fs_valid, fs_inst, fs_pc
    );

    modport slave (
        output pc_in, pc_valid, flush, inst_addr_ok, inst_data_ok, inst_rdata, ds_allow_in,
        input  inst_req, inst_addr, fs_addr_ok, fs_data_ok, fs_valid, fs_inst, fs_pc
    );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: issues like-SRAM fetch requests from next-PC values, tags
// returned words with their PC and buffers {pc,inst} for decode. Flush kills in-flight
// fetches via a discard counter plus a kill flag on an unaccepted request.
// Optional feature macro FETCH_BYPASS_EN: a returned word may reach decode in the same
// cycle when the output FIFO is empty.
module inst_fetch_unit #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned MAX_OUTST = 2
) (
    input  logic           clk,
    input  logic           resetn,
    inst_fetch_unit_if.master fif
);
    localparam int unsigned FPW = $clog2(DEPTH);
    localparam int unsigned FCW = $clog2(DEPTH + 1);
    localparam int unsigned TPW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int unsigned OCW = $clog2(MAX_OUTST + 1);

    typedef enum logic {ST_IDLE, ST_REQ} state_t;

    state_t          r_state, w_state_nxt;
    logic [31:0]     r_inst_addr;
    logic            r_kill;
    logic [31:0]     r_tag [MAX_OUTST];
    logic [TPW-1:0]  r_tag_rd, r_tag_wr, w_tag_rd_inc, w_tag_wr_inc;
    logic [OCW-1:0]  r_outst_cnt, r_discard_cnt, w_outst_nxt, w_discard_nxt;
    logic [31:0]     r_fifo_pc   [DEPTH];
    logic [31:0]     r_fifo_inst [DEPTH];
    logic [FPW-1:0]  r_rd_ptr, r_wr_ptr;
    logic [FCW-1:0]  r_fifo_cnt, w_fifo_nxt;
    logic            w_acc, w_ret, w_drop, w_keep, w_push, w_pop, w_latch;
    logic            w_credit_idle, w_credit_req, w_fifo_empty;
    logic [31:0]     w_tag;

    assign w_acc        = (r_state == ST_REQ) & fif.inst_addr_ok;
    // data_ok with nothing outstanding is a bus protocol error and is ignored
    assign w_ret        = fif.inst_data_ok & (r_outst_cnt != '0);
    assign w_drop       = w_ret & (r_discard_cnt != '0);
    assign w_keep       = w_ret & ~w_drop;
    assign w_tag        = r_tag[r_tag_rd];
    assign w_fifo_empty = (r_fifo_cnt == '0);
    assign w_tag_rd_inc = (r_tag_rd == TPW'(MAX_OUTST - 1)) ? '0 : r_tag_rd + 1'b1;
    assign w_tag_wr_inc = (r_tag_wr == TPW'(MAX_OUTST - 1)) ? '0 : r_tag_wr + 1'b1;

    assign w_outst_nxt  = r_outst_cnt + OCW'(w_acc) - OCW'(w_ret);
    assign w_fifo_nxt   = fif.flush ? '0 : r_fifo_cnt + FCW'(w_push) - FCW'(w_pop);

    // IDLE uses the current occupancy; back-to-back issue uses occupancy after this
    // cycle's accept/return/pop so a steady stream needs no bubble
    assign w_credit_idle = (32'(r_fifo_cnt) + 32'(r_outst_cnt) < DEPTH) && (32'(r_outst_cnt) < MAX_OUTST);
    assign w_credit_req  = (32'(w_fifo_nxt) + 32'(w_outst_nxt) < DEPTH) && (32'(w_outst_nxt) < MAX_OUTST);

    assign fif.inst_req   = (r_state == ST_REQ);
    assign fif.inst_addr  = r_inst_addr;
    assign fif.fs_addr_ok = fif.inst_req & fif.inst_addr_ok;
    assign fif.fs_data_ok = fif.inst_data_ok;
    assign w_pop          = ~w_fifo_empty & fif.ds_allow_in;

`ifdef FETCH_BYPASS_EN
    logic w_bypass;
    assign w_bypass     = w_fifo_empty & w_keep & ~fif.flush;
    assign w_push       = w_keep & ~fif.flush & ~(w_bypass & fif.ds_allow_in);
    assign fif.fs_valid = ~w_fifo_empty | w_bypass;
    assign fif.fs_inst  = w_bypass ? fif.inst_rdata : r_fifo_inst[r_rd_ptr];
    assign fif.fs_pc    = w_bypass ? w_tag : r_fifo_pc[r_rd_ptr];
`else
    assign w_push       = w_keep & ~fif.flush;
    assign fif.fs_valid = ~w_fifo_empty;
    assign fif.fs_inst  = r_fifo_inst[r_rd_ptr];
    assign fif.fs_pc    = r_fifo_pc[r_rd_ptr];
`endif

    // discard count after flush covers every request still owed data after this edge;
    // an unaccepted killed request joins the count when it is finally accepted
    always_comb begin
        if (fif.flush) w_discard_nxt = w_outst_nxt;
        else           w_discard_nxt = r_discard_cnt - OCW'(w_drop) + OCW'(w_acc & r_kill);
    end

    // next-state logic: latch a new fetch when credit allows and no flush this cycle
    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!fif.flush && fif.pc_valid && w_credit_idle) begin
                    w_latch     = 1'b1;
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (fif.inst_addr_ok) begin
                    if (!fif.flush && fif.pc_valid && w_credit_req) w_latch = 1'b1;
                    else                                            w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // request register: state, held address and kill flag of the pending request
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_inst_addr <= '0;
            r_kill      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_latch) begin
                r_inst_addr <= {fif.pc_in[31:2], 2'b00};
                r_kill      <= 1'b0;
            end else if (fif.flush && (r_state == ST_REQ) && !fif.inst_addr_ok) begin
                r_kill      <= 1'b1;
            end else if (w_acc) begin
                r_kill      <= 1'b0;
            end
        end
    end

    // tag queue and outstanding/discard counters
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < MAX_OUTST; i++) r_tag[i] <= '0;
            r_tag_rd      <= '0;
            r_tag_wr      <= '0;
            r_outst_cnt   <= '0;
            r_discard_cnt <= '0;
        end else begin
            if (w_acc) begin
                r_tag[r_tag_wr] <= r_inst_addr;
                r_tag_wr        <= w_tag_wr_inc;
            end
            if (w_ret) r_tag_rd <= w_tag_rd_inc;
            r_outst_cnt   <= w_outst_nxt;
            r_discard_cnt <= w_discard_nxt;
        end
    end

    // output FIFO of {pc,inst}; flush empties it, including any push that cycle
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_fifo_pc[i]   <= '0;
                r_fifo_inst[i] <= '0;
            end
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_fifo_cnt <= '0;
        end else begin
            if (fif.flush) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
            end else begin
                if (w_push) begin
                    r_fifo_pc[r_wr_ptr]   <= w_tag;
                    r_fifo_inst[r_wr_ptr] <= fif.inst_rdata;
                    r_wr_ptr              <= r_wr_ptr + 1'b1;
                end
                if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_fifo_cnt <= w_fifo_nxt;
        end
    end
endmodule

// File: tb/tb_inst_fetch_unit.sv
// Testbench for inst_fetch_unit: acts as PC calculator, instruction bus slave and
// decode stage, and compares against a transaction-level model of requests and words.
`timescale 1ns/1ps
module tb_inst_fetch_unit;
    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    inst_fetch_unit_if fif();

    inst_fetch_unit #(.DEPTH(4), .MAX_OUTST(2)) dut (
        .clk    (clk),
        .resetn (resetn),
        .fif    (fif)
    );

    typedef struct { logic [31:0] addr; bit killed; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] inst; } word_t;

    req_t        outq[$];
    word_t       expq[$];
    logic [31:0] popped[$];
    req_t        r;
    word_t       w;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          acc_cnt  = 0;
    int          acc0;
    logic [31:0] prev_pc, hold_addr, nxt_pc, redirect_target;
    bit          prev_req, prev_acc, prev_pcv, prev_flush, cur_killed, redirect_pending;
    logic        fl;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // model update: one cycle of bus/decode/flush events, sampled mid-cycle
    always @(negedge clk) begin
        if (!resetn) begin
            outq.delete();
            expq.delete();
            prev_req = 0; prev_acc = 0; prev_pcv = 0; prev_flush = 0;
            cur_killed = 0; redirect_pending = 0; nxt_pc = 32'hbfc00000; prev_pc = '0;
        end else begin
            check("credit", 32'(outq.size() <= 2 && outq.size() + expq.size() <= 4), 1);
            check("fs_valid", 32'(fif.fs_valid), 32'(expq.size() != 0));
            if (fif.fs_valid && expq.size() != 0) begin
                check("fs_pc", fif.fs_pc, expq[0].pc);
                check("fs_inst", fif.fs_inst, expq[0].inst);
            end
            check("fs_addr_ok", 32'(fif.fs_addr_ok), 32'(fif.inst_req & fif.inst_addr_ok));
            check("fs_data_ok", 32'(fif.fs_data_ok), 32'(fif.inst_data_ok));
            if (fif.fs_valid && fif.ds_allow_in && expq.size() != 0) begin
                w = expq.pop_front();
                popped.push_back(w.pc);
            end
            if (fif.inst_req) begin
                if (!prev_req || prev_acc) begin
                    check("req_src", 32'(prev_pcv && !prev_flush), 1);
                    check("req_addr", fif.inst_addr, {prev_pc[31:2], 2'b00});
                    nxt_pc = fif.inst_addr + 32'd4;
                    redirect_pending = 0;
                end else begin
                    check("addr_hold", fif.inst_addr, hold_addr);
                end
                hold_addr = fif.inst_addr;
            end
            if (fif.inst_data_ok && outq.size() != 0) begin
                r = outq.pop_front();
                if (!r.killed && !fif.flush) expq.push_back('{r.addr, fif.inst_rdata});
            end
            if (fif.inst_req && fif.inst_addr_ok) begin
                outq.push_back('{fif.inst_addr, cur_killed});
                cur_killed = 0;
                acc_cnt++;
            end
            if (fif.flush) begin
                foreach (outq[i]) outq[i].killed = 1;
                if (fif.inst_req && !fif.inst_addr_ok) cur_killed = 1;
                expq.delete();
                popped.delete();
                redirect_pending = 1;
                nxt_pc = redirect_target;
            end
            prev_req   = fif.inst_req;
            prev_acc   = fif.inst_req && fif.inst_addr_ok;
            prev_pcv   = fif.pc_valid;
            prev_flush = fif.flush;
            prev_pc    = fif.pc_in;
        end
    end

    // one cycle of stimulus; pc_in follows the stream unless a redirect is pending
    task automatic drive(input bit pcv, input bit aok, input bit dok, input bit ds, input bit f);
        @(posedge clk);
        #1;
        fif.pc_valid     = pcv;
        fif.inst_addr_ok = aok;
        fif.inst_data_ok = dok && (outq.size() != 0);
        fif.inst_rdata   = $urandom;
        fif.ds_allow_in  = ds;
        fif.flush        = f;
        fif.pc_in        = (redirect_pending ? nxt_pc
                           : (fif.inst_req ? fif.inst_addr + 32'd4 : nxt_pc))
                           | 32'($urandom_range(0, 3));
    endtask

    initial begin
        resetn = 1'b0;
        fif.pc_in = '0; fif.pc_valid = 0; fif.flush = 0; fif.inst_addr_ok = 0;
        fif.inst_data_ok = 0; fif.inst_rdata = '0; fif.ds_allow_in = 0;
        redirect_target = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req", 32'(fif.inst_req), 0);
        check("rst_addr", fif.inst_addr, 0);
        check("rst_valid", 32'(fif.fs_valid), 0);
        check("rst_inst", fif.fs_inst, 0);
        check("rst_pc", fif.fs_pc, 0);
        resetn = 1'b1;

        // straight-line fetch from the reset vector
        popped.delete();
        repeat (3) drive(1, 1, 1, 1, 0);
        repeat (8) drive(0, 1, 1, 1, 0);
        check("line_cnt", 32'(popped.size()), 3);
        if (popped.size() == 3) begin
            check("line_pc0", popped[0], 32'hbfc00000);
            check("line_pc1", popped[1], 32'hbfc00004);
            check("line_pc2", popped[2], 32'hbfc00008);
        end

        // backpressure: decode stalled, only DEPTH requests may go out
        acc0 = acc_cnt;
        repeat (16) drive(1, 1, 1, 0, 0);
        check("bp_reqs", 32'(acc_cnt - acc0), 4);
        check("bp_req_low", 32'(fif.inst_req), 0);
        repeat (12) drive(1, 1, 1, 1, 0);
        check("bp_resume", 32'(acc_cnt - acc0 > 4), 1);
        repeat (10) drive(0, 1, 1, 1, 0);

        // bus stall on a redirected fetch
        redirect_target = 32'hbfc00010;
        drive(0, 0, 0, 1, 1);
        drive(1, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 1, 0);
            check("stall_req", 32'(fif.inst_req), 1);
            check("stall_addr", fif.inst_addr, 32'hbfc00010);
        end

        // asynchronous reset in the middle of a request
        @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        check("arst_req", 32'(fif.inst_req), 0);
        check("arst_valid", 32'(fif.fs_valid), 0);
        check("arst_pc", fif.fs_pc, 0);
        repeat (2) drive(0, 0, 0, 1, 0);
        resetn = 1'b1;

        // flush with outstanding requests, then redirect
        repeat (3) drive(1, 1, 0, 1, 0);
        redirect_target = 32'hbfc00380;
        drive(0, 0, 0, 1, 1);
        repeat (3) drive(1, 1, 1, 1, 0);
        repeat (10) drive(0, 1, 1, 1, 0);
        check("flush_cnt", 32'(popped.size() != 0), 1);
        if (popped.size() != 0) check("flush_pc0", popped[0], 32'hbfc00380);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            fl = ($urandom_range(0, 99) < 3);
            if (fl) redirect_target = $urandom & 32'hfffffffc;
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0, fl);
        end
        repeat (20) drive(0, 1, 1, 1, 0);
        check("drain_exp", 32'(expq.size()), 0);
        check("drain_outst", 32'(outq.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
